ddr2_sys_st_timing_adapter_fifo: RTL
====================================

Name: ddr2_sys_st_timing_adapter_fifo

Overview:
Parametrised Avalon-ST timing adapter for the DDR2 debug-master path. Converts an upstream interface with ready latency IN_RL into a downstream interface with ready latency 0. An internal FIFO absorbs beats already in flight when the downstream applies backpressure. Unlike the pass-through generation, it raises in_ready for real backpressure and flags overflow instead of silently dropping data.

Parameters:
DATA_W, 8, payload width in bits.
DEPTH, 4, FIFO entries; power of 2; must be >= IN_RL+2.
IN_RL, 1, upstream ready latency in cycles, 0..3.
CNT_W, $clog2(DEPTH)+1, fill-counter width; derived, not overridable.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous reset, active-high.
in_valid  in  1  upstream beat valid.
in_data  in  DATA_W  upstream payload.
in_ready  out  1  upstream ready; upstream may assert in_valid in cycle t only if in_ready was high in cycle t-IN_RL.
out_valid  out  1  downstream beat valid.
out_data  out  DATA_W  downstream payload (FIFO head).
out_ready  in  1  downstream ready, latency 0.
fill_level  out  CNT_W  current FIFO occupancy, 0..DEPTH.
overflow  out  1  sticky; set when a beat arrives while the FIFO is full and no pop occurs.

Behaviour:
- Reset: synchronous, active-high. Applies at the next clk edge and also mid-operation.
  - Reset values: rd_ptr=0, wr_ptr=0, count=0, fill_level=0, out_valid=0, overflow=0, in_ready=0 while reset is high.
  - FIFO contents are not cleared. out_data is don't-care while out_valid=0.
- Push: in_valid=1. Pop: out_valid && out_ready.
- Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Push into a full FIFO with no pop:
  - the beat is dropped;
  - overflow is set to 1 and stays set until reset;
  - count is unchanged.
- Count update: push only → count+1; pop only → count-1; push and pop together → unchanged. Pointers wrap modulo DEPTH.
- out_valid = (count != 0). out_data = mem[rd_ptr]. Both are driven from registers; no combinational path from in_* to out_*.
- Latency: a beat pushed in cycle t appears on out_valid/out_data in cycle t+1. An empty FIFO has no bypass.
- in_ready = !reset && ((DEPTH - count) > IN_RL), decoded from the registered count.
  - This guarantees room for the IN_RL beats that may already be in flight.
  - in_ready has no combinational dependency on out_ready.
- Throughput: with out_ready held at 1, 1 beat/cycle is sustained indefinitely.
- Ordering: strict FIFO order; no reordering, no duplication.
- Width: fill_level = count, zero-extended; it never exceeds DEPTH.
- Simulation only: an assertion fires on overflow rising, reporting the protocol violation by the upstream.
- Elaboration: a check fails elaboration if DEPTH < IN_RL+2 or DEPTH is not a power of 2.

Decomposition:
- Shared package ddr2_sys_st_pkg holds:
  - constant ST_MAX_RL=3;
  - a function for ceiling-log2 width;
  - typedef st_fill_t for occupancy.
- One sub-module, ddr2_sys_st_fifo_mem: DEPTH×DATA_W register array with write port (we, waddr, wdata) and asynchronous read (raddr → rdata).
- Pointers, count, ready decode and overflow logic live in the top module.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, then 0 → out_valid=0, fill_level=0, overflow=0. in_ready=0 during reset and 1 in the first cycle after release (DEPTH=4, IN_RL=1).
- Streaming: out_ready=1; push 0x01..0x10 on consecutive cycles → out_data 0x01..0x10 in order, each one cycle after its push, with no gaps; fill_level ≤1.
- Backpressure: out_ready=0; push 0xA0,0xA1,0xA2 → after the 3rd push fill_level=3 and in_ready=0. 0xA3 arrives in flight (IN_RL=1) → fill_level=4, overflow=0. Then out_ready=1 → drains 0xA0..0xA3 in order.
- Overflow: FIFO full (DEPTH=4), out_ready=0, push 0xEE → overflow=1, fill_level stays 4, 0xEE never appears at the output; overflow stays 1 after draining.
- Full with simultaneous push/pop: count=4, out_ready=1, push 0x55 → count stays 4, overflow=0, and 0x55 emerges after the 4 older beats.
- Reset mid-stream: fill_level=3, assert reset for 1 cycle → next cycle out_valid=0, fill_level=0, overflow=0. A subsequent push of 0x77 is output as 0x77 one cycle later.

Source files
------------

// File: rtl/ddr2_sys_st_timing_adapter_fifo_pkg.sv
// Shared types and helpers for the DDR2 debug-master Avalon-ST timing adapter.
// Pure declarations: no logic, no latency, no flow control.
package ddr2_sys_st_pkg;

    localparam int ST_MAX_RL = 3;
    localparam int ST_FILL_W = 8;

    typedef logic [ST_FILL_W-1:0] st_fill_t;

    function automatic int clog2_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr2_sys_st_timing_adapter_fifo_if.sv
// Avalon-ST valid/ready/data bundle; master drives valid and data, slave drives ready.
// Pure wiring: no latency, ready semantics defined by the connected modules.
interface ddr2_sys_st_timing_adapter_fifo_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ddr2_sys_st_timing_adapter_fifo_mem.sv
// DEPTH x DATA_W register array, one write port, asynchronous read port.
// Write lands on the next clk edge; read is combinational; no flow control.
module ddr2_sys_st_fifo_mem
    import ddr2_sys_st_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = clog2_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ddr2_sys_st_timing_adapter_fifo.sv
// Ready-latency IN_RL to ready-latency 0 adapter with a DEPTH-entry FIFO; push-to-output latency 1 cycle.
// in_ready drops once headroom can no longer absorb IN_RL in-flight beats; beats into a full FIFO set sticky overflow.
module ddr2_sys_st_timing_adapter_fifo
    import ddr2_sys_st_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int IN_RL  = 1,
    localparam int CNT_W = clog2_w(DEPTH) + 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    ddr2_sys_st_timing_adapter_fifo_if.slave         up,
    ddr2_sys_st_timing_adapter_fifo_if.master        dn,
    output logic [CNT_W-1:0]                         fill_level,
    output logic                                     overflow
);

    localparam int AW = clog2_w(DEPTH);

    if (DEPTH < IN_RL + 2 || (DEPTH & (DEPTH - 1)) != 0 || IN_RL < 0 || IN_RL > ST_MAX_RL) begin : g_bad_cfg
        $error("ddr2_sys_st_timing_adapter_fifo: illegal DEPTH/IN_RL combination");
    end

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop;
    st_fill_t         headroom;

    assign push   = up.valid;
    assign pop    = dn.valid && dn.ready;
    assign full   = (count == CNT_W'(DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    ddr2_sys_st_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (up.data),
        .raddr (rd_ptr),
        .rdata (dn.data)
    );

    // Ready is decoded from registered occupancy only, so it never depends on out_ready.
    assign headroom   = st_fill_t'(DEPTH) - st_fill_t'(count);
    assign up.ready   = !reset && (headroom > st_fill_t'(IN_RL));
    assign dn.valid   = (count != '0);
    assign fill_level = count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(drop && !overflow))
            else $warning("ddr2_sys_st_timing_adapter_fifo: upstream sent a beat into a full FIFO, beat dropped");
        end
    end

endmodule
